// File: rtl/sel_mux_scanner.sv
// ---------------------------------------------------------------------------
// sel_mux_scanner
//
// Registered word selector with a valid/ready output port. Picks one of
// NUM_IN words of WIDTH bits either on demand (single-shot by index) or
// streams every channel 0..NUM_IN-1 in order (auto-scan), honouring
// downstream backpressure.
//
// Optional build macro: SEL_MUX_SCANNER_PARITY_EN
//   When defined, adds out_parity = XOR-reduction of the word held in
//   out_data, registered on the same edge as out_data (reset value 0).
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   d_in        in   flattened inputs, channel k at [k*WIDTH +: WIDTH]
//   sel         in   channel index for a single-shot request
//   sel_valid   in   single-shot request strobe (sampled only in IDLE)
//   scan_start  in   scan request strobe (sampled only in IDLE)
//   out_data    out  registered selected word
//   out_ch      out  channel index of out_data
//   out_valid   out  out_data/out_ch valid
//   out_ready   in   consumer accepts the current word
//   busy        out  high whenever the FSM is not IDLE
//   sel_err     out  one-cycle pulse on an out-of-range single-shot index
//   out_parity  out  (parity build only) XOR of out_data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for sel_valid / scan_start; outputs not valid
// HOLD  | single-shot word presented until out_ready
// SCAN  | streaming channels, out_ch is the scan position
// ---------------------------------------------------------------------------
module sel_mux_scanner #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 32,
  parameter int SEL_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] d_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  input  logic                    scan_start,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    sel_err
`ifdef SEL_MUX_SCANNER_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  // Every index value the sel port can express gets a slot; slots past
  // NUM_IN read as zero so no index ever selects an undriven word.
  localparam int NUM_SLOT = 2 ** SEL_W;
  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W + 1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_ch_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               sel_err_q;

  logic [WIDTH-1:0]   ch_w [NUM_SLOT];

  logic               sel_ok_d;
  logic               last_ch_d;
  logic [SEL_W-1:0]   ch_next_d;
  logic               load_en_d;
  logic [WIDTH-1:0]   load_word_d;
  logic [SEL_W-1:0]   load_ch_d;

  for (genvar g = 0; g < NUM_SLOT; g++) begin : g_ch
    if (g < NUM_IN) begin : g_live
      assign ch_w[g] = d_in[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_w[g] = '0;
    end
  end

  assign sel_ok_d  = ({1'b0, sel} < NUM_IN_W);
  assign last_ch_d = (out_ch_q == LAST_CH);
  assign ch_next_d = out_ch_q + SEL_W'(1);

  // Which word (if any) gets captured on this edge. Kept separate from the
  // state register so the data/parity capture sits in one place.
  always_comb begin
    load_en_d   = 1'b0;
    load_word_d = '0;
    load_ch_d   = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (sel_ok_d) begin
            load_en_d   = 1'b1;
            load_word_d = ch_w[sel];
            load_ch_d   = sel;
          end
        end else if (scan_start) begin
          load_en_d   = 1'b1;
          load_word_d = ch_w[0];
          load_ch_d   = '0;
        end
      end
      SCAN: begin
        if (out_ready && !last_ch_d) begin
          load_en_d   = 1'b1;
          load_word_d = ch_w[ch_next_d];
          load_ch_d   = ch_next_d;
        end
      end
      default: begin
        load_en_d = 1'b0;
      end
    endcase
  end

`ifdef SEL_MUX_SCANNER_PARITY_EN
  logic out_parity_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
`ifdef SEL_MUX_SCANNER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      sel_err_q <= 1'b0;

      if (load_en_d) begin
        out_data_q <= load_word_d;
        out_ch_q   <= load_ch_d;
`ifdef SEL_MUX_SCANNER_PARITY_EN
        out_parity_q <= ^load_word_d;
`endif
      end

      case (state_q)
        IDLE: begin
          // sel_valid has priority; a simultaneous scan_start is dropped.
          if (sel_valid) begin
            if (sel_ok_d) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              sel_err_q <= 1'b1;
            end
          end else if (scan_start) begin
            state_q     <= SCAN;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        SCAN: begin
          if (out_ready && last_ch_d) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sel_err   = sel_err_q;
`ifdef SEL_MUX_SCANNER_PARITY_EN
  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_sel_mux_scanner.sv
module tb_sel_mux_scanner;

  logic clk;
  logic reset_n;

  // 32-channel instance
  logic [32*32-1:0] d32;
  logic [4:0]       sel;
  logic             sv, ss, rdy;
  logic [31:0]      od32;
  logic [4:0]       och32;
  logic             ov32, busy32, err32;

  // 20-channel instance for out-of-range checks
  logic [20*32-1:0] d20;
  logic [4:0]       sel20;
  logic             sv20, ss20, rdy20;
  logic [31:0]      od20;
  logic [4:0]       och20;
  logic             ov20, busy20, err20;

`ifdef SEL_MUX_SCANNER_PARITY_EN
  logic par32, par20;
`endif

  logic [31:0] m32 [32];
  logic [31:0] m20 [20];

  int n_tests = 0;
  int n_fail  = 0;

  sel_mux_scanner #(.WIDTH(32), .NUM_IN(32), .SEL_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .d_in(d32), .sel(sel), .sel_valid(sv),
    .scan_start(ss), .out_data(od32), .out_ch(och32), .out_valid(ov32),
    .out_ready(rdy), .busy(busy32), .sel_err(err32)
`ifdef SEL_MUX_SCANNER_PARITY_EN
    , .out_parity(par32)
`endif
  );

  sel_mux_scanner #(.WIDTH(32), .NUM_IN(20), .SEL_W(5)) dut20 (
    .clk(clk), .reset_n(reset_n), .d_in(d20), .sel(sel20), .sel_valid(sv20),
    .scan_start(ss20), .out_data(od20), .out_ch(och20), .out_valid(ov20),
    .out_ready(rdy20), .busy(busy20), .sel_err(err20)
`ifdef SEL_MUX_SCANNER_PARITY_EN
    , .out_parity(par20)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_d();
    for (int k = 0; k < 32; k++) d32[k*32 +: 32] = m32[k];
    for (int k = 0; k < 20; k++) d20[k*32 +: 32] = m20[k];
  endtask

  task automatic randomize_m32();
    for (int k = 0; k < 32; k++) m32[k] = $urandom;
    load_d();
  endtask

  initial begin
    logic [31:0] held;
    int n, cyc, k, w;
    logic r;

    reset_n = 1'b0;
    sel = '0; sv = 0; ss = 0; rdy = 0;
    sel20 = '0; sv20 = 0; ss20 = 0; rdy20 = 0;
    for (int i = 0; i < 32; i++) m32[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 20; i++) m20[i] = $urandom;
    load_d();

    repeat (2) step();
    chk("rst_data",  64'(od32),   64'(0));
    chk("rst_ch",    64'(och32),  64'(0));
    chk("rst_valid", 64'(ov32),   64'(0));
    chk("rst_busy",  64'(busy32), 64'(0));
    chk("rst_err",   64'(err32),  64'(0));
    chk("rst_valid20", 64'(ov20), 64'(0));
    reset_n = 1'b1;
    step();

    // Single select with 3 cycles of backpressure
    sel = 5'd5; sv = 1; step(); sv = 0;
    held = 32'h1000_0005;
    chk("ss_data",  64'(od32),   64'(held));
    chk("ss_ch",    64'(och32),  64'(5));
    chk("ss_valid", 64'(ov32),   64'(1));
    chk("ss_busy",  64'(busy32), 64'(1));
    randomize_m32();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ss_hold_valid", 64'(ov32),   64'(1));
      chk("ss_hold_data",  64'(od32),   64'(held));
      chk("ss_hold_busy",  64'(busy32), 64'(1));
    end
    rdy = 1; step(); rdy = 0;
    chk("ss_done_valid", 64'(ov32),   64'(0));
    chk("ss_done_busy",  64'(busy32), 64'(0));
    chk("ss_done_data",  64'(od32),   64'(held));

    // Back-to-back: request held across the handshake is taken one cycle later
    sel = 5'd7; sv = 1; step();
    chk("b2b_ch1", 64'(och32), 64'(7));
    sel = 5'd9; rdy = 1; step(); rdy = 0;
    chk("b2b_gap_valid", 64'(ov32), 64'(0));
    step(); sv = 0;
    chk("b2b_valid2", 64'(ov32),  64'(1));
    chk("b2b_ch2",    64'(och32), 64'(9));
    chk("b2b_data2",  64'(od32),  64'(m32[9]));
    rdy = 1; step(); rdy = 0;
    chk("b2b_end", 64'(ov32), 64'(0));

    // Out-of-range on the 20-channel instance
    sel20 = 5'd2; sv20 = 1; step(); sv20 = 0;
    chk("r20_data", 64'(od20), 64'(m20[2]));
    rdy20 = 1; step(); rdy20 = 0;
    chk("r20_idle", 64'(ov20), 64'(0));
    sel20 = 5'd25; sv20 = 1; step(); sv20 = 0;
    chk("oor_err",   64'(err20),  64'(1));
    chk("oor_valid", 64'(ov20),   64'(0));
    chk("oor_busy",  64'(busy20), 64'(0));
    chk("oor_data",  64'(od20),   64'(m20[2]));
    step();
    chk("oor_err_pulse", 64'(err20), 64'(0));
    chk("oor_valid2",    64'(ov20),  64'(0));
    sel20 = 5'd20; sv20 = 1; step(); sv20 = 0;
    chk("oor20_err",   64'(err20), 64'(1));
    chk("oor20_valid", 64'(ov20),  64'(0));
    sel20 = 5'd19; sv20 = 1; step(); sv20 = 0;
    chk("top20_err",  64'(err20), 64'(0));
    chk("top20_data", 64'(od20),  64'(m20[19]));
    chk("top20_ch",   64'(och20), 64'(19));
    rdy20 = 1; step(); rdy20 = 0;

    // Full scan with ready tied high
    for (int i = 0; i < 32; i++) m32[i] = 32'h1000_0000 + i;
    load_d();
    rdy = 1; ss = 1; step(); ss = 0;
    for (int i = 0; i < 32; i++) begin
      chk("scan_valid", 64'(ov32),  64'(1));
      chk("scan_ch",    64'(och32), 64'(i));
      chk("scan_data",  64'(od32),  64'(m32[i]));
      step();
    end
    rdy = 0;
    chk("scan_end_valid", 64'(ov32),   64'(0));
    chk("scan_end_busy",  64'(busy32), 64'(0));

    // Scans with backpressure: fixed 1,0,0 pattern then random ready
    for (int it = 0; it < 4; it++) begin
      randomize_m32();
      ss = 1; step(); ss = 0;
      n = 0; cyc = 0;
      while (n < 32 && cyc < 2000) begin
        chk("bp_valid", 64'(ov32),  64'(1));
        chk("bp_ch",    64'(och32), 64'(n));
        chk("bp_data",  64'(od32),  64'(m32[n]));
        r = (it == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        rdy = r;
        step();
        if (r) n++;
        cyc++;
      end
      rdy = 0;
      chk("bp_count",    64'(n),      64'(32));
      chk("bp_end_valid", 64'(ov32),  64'(0));
      chk("bp_end_busy", 64'(busy32), 64'(0));
    end

    // Priority: sel_valid beats scan_start
    sel = 5'd3; sv = 1; ss = 1; step(); sv = 0; ss = 0;
    chk("pri_ch",    64'(och32), 64'(3));
    chk("pri_data",  64'(od32),  64'(m32[3]));
    chk("pri_valid", 64'(ov32),  64'(1));
    rdy = 1; step(); rdy = 0;
    chk("pri_done", 64'(ov32), 64'(0));
    step();
    chk("pri_noscan_valid", 64'(ov32),   64'(0));
    chk("pri_noscan_busy",  64'(busy32), 64'(0));

    // Random single shots
    for (int it = 0; it < 20; it++) begin
      randomize_m32();
      k = $urandom_range(0, 31);
      sel = 5'(k); sv = 1; ss = 1'($urandom_range(0, 1)); step(); sv = 0; ss = 0;
      held = m32[k];
      chk("rnd_ch",   64'(och32), 64'(k));
      chk("rnd_data", 64'(od32),  64'(held));
`ifdef SEL_MUX_SCANNER_PARITY_EN
      chk("rnd_par", 64'(par32), 64'(^held));
`endif
      randomize_m32();
      w = $urandom_range(0, 3);
      for (int j = 0; j < w; j++) begin
        step();
        chk("rnd_hold", 64'(od32), 64'(held));
      end
      rdy = 1; step(); rdy = 0;
      chk("rnd_done", 64'(ov32), 64'(0));
    end

`ifdef SEL_MUX_SCANNER_PARITY_EN
    m32[4] = 32'h0000_0007; m32[6] = 32'h0000_0003; load_d();
    sel = 5'd4; sv = 1; step(); sv = 0;
    chk("par_7", 64'(par32), 64'(1));
    rdy = 1; step(); rdy = 0;
    sel = 5'd6; sv = 1; step(); sv = 0;
    chk("par_3", 64'(par32), 64'(0));
    rdy = 1; step(); rdy = 0;
`endif

    // Reset mid-scan at channel 10
    rdy = 1; ss = 1; step(); ss = 0;
    cyc = 0;
    while (och32 !== 5'd10 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("mid_ch10", 64'(och32), 64'(10));
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_data",  64'(od32),   64'(0));
    chk("mrst_ch",    64'(och32),  64'(0));
    chk("mrst_valid", 64'(ov32),   64'(0));
    chk("mrst_busy",  64'(busy32), 64'(0));
    chk("mrst_err",   64'(err32),  64'(0));
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 64'(ov32),   64'(0));
      chk("post_rst_busy",  64'(busy32), 64'(0));
    end
    rdy = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sel_mux_scanner.md
Name: sel_mux_scanner

Overview:
- Parametrised, registered successor to the flat 32-to-1 word selector.
- Selects one of NUM_IN words of WIDTH bits and presents it on a valid/ready output port.
- Two modes:
  - single-shot select by index;
  - auto-scan that streams every channel 0..NUM_IN-1 in order.
- Sits between the factorial datapath register bank and downstream consumers (result readout, debug dump).

Parameters:
- WIDTH, 32, bit width of each data word.
- NUM_IN, 32, number of input channels; legal range 2..2**SEL_W.
- SEL_W, 5, width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- d_in  input  NUM_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel index for a single-shot request.
- sel_valid  input  1  single-shot request strobe; sampled only in IDLE.
- scan_start  input  1  scan request strobe; sampled only in IDLE.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  consumer accepts the current word.
- busy  output  1  high whenever state is not IDLE.
- sel_err  output  1  one-cycle pulse when sel >= NUM_IN.

Behaviour:
- Reset (asynchronous on reset_n low): immediately clears state to IDLE and clears the following:
  - out_data = 0, out_ch = 0;
  - out_valid = 0, busy = 0, sel_err = 0;
  - scan counter = 0.
  - Reset mid-transfer or mid-scan aborts with no further output.
- States: IDLE, HOLD, SCAN. busy = (state != IDLE), registered.
- IDLE, sel_valid = 1 and sel < NUM_IN:
  - next edge loads out_data = d_in[sel] and out_ch = sel;
  - sets out_valid = 1 and goes to HOLD.
  - Latency: one edge.
- IDLE, sel_valid = 1 and sel >= NUM_IN:
  - sel_err = 1 for exactly one cycle;
  - out_valid stays 0 and out_data is unchanged; state stays IDLE.
  - No X is ever driven.
- IDLE, scan_start = 1 with sel_valid = 0:
  - next edge loads out_data = d_in[0] and out_ch = 0;
  - sets out_valid = 1 and goes to SCAN.
- sel_valid and scan_start both high in IDLE: sel_valid wins; scan_start is dropped.
- HOLD:
  - out_data/out_ch are frozen; out_valid stays 1 until out_ready = 1 at an edge.
  - On that edge out_valid = 0 and the state goes to IDLE.
  - out_data keeps its last value after the transfer.
- SCAN, with current channel k, on an edge where out_valid = 1 and out_ready = 1:
  - if k == NUM_IN-1: out_valid = 0, IDLE;
  - else: out_data = d_in[k+1], out_ch = k+1, out_valid stays 1.
  - Without out_ready the word holds (backpressure).
  - With out_ready held high, the NUM_IN words come out on NUM_IN consecutive cycles.
- Sampling: d_in is sampled only on load edges. Later changes to d_in do not affect a held word.
- sel_valid and scan_start are ignored while busy = 1.
- Back-to-back: a new request can be accepted in the cycle after the return to IDLE. There is no same-edge restart.

Optional Feature:
- Macro: SEL_MUX_SCANNER_PARITY_EN.
- When defined:
  - adds output out_parity (1 bit) = XOR-reduction of the word loaded into out_data;
  - out_parity is registered on the same edge as out_data;
  - reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single select, WIDTH=32 and NUM_IN=32, d_in[k] = 32'h1000_0000 + k:
  - stimulus: sel=5, sel_valid one cycle, out_ready=0 for 3 cycles then 1;
  - response: out_data = 32'h1000_0005 and out_ch = 5 one edge after the request;
  - out_valid held 3+ cycles, cleared on the edge after out_ready rises; busy mirrors this.
- Out-of-range, NUM_IN=20 and SEL_W=5:
  - stimulus: sel=25 with sel_valid;
  - response: sel_err high exactly one cycle, out_valid = 0, busy = 0, out_data unchanged.
- Full scan with out_ready tied high and NUM_IN=32:
  - response: out_valid high 32 consecutive cycles;
  - out_ch sequence 0..31, out_data = d_in[out_ch] each cycle;
  - returns to IDLE with busy = 0.
- Scan with backpressure: out_ready toggles 1,0,0,1...
  - response: each word is held while out_ready = 0;
  - no channel is skipped or repeated; 32 words are delivered in total.
- Priority and reset:
  - sel_valid=1 (sel=3) and scan_start=1 in the same cycle -> single-shot of channel 3 only;
  - reset_n pulled low while out_ch = 10 mid-scan -> all outputs 0 immediately;
  - no output resumes after reset_n rises.
- Parity build with SEL_W_MUX_SCANNER_PARITY_EN... corrected macro SEL_MUX_SCANNER_PARITY_EN defined:
  - select a word 32'h0000_0007 -> out_parity = 1;
  - select a word 32'h0000_0003 -> out_parity = 0.
